// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    // Loader FSM states; receive states are LEN_HI through CHECK.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    // Values reported on error_code_out.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // A word count is usable when non-zero and it fits the memory without wrapping.
    function automatic logic length_ok(input logic [15:0] n, input int unsigned depth);
        return (n != 16'd0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Counts idle cycles between accepted bytes; flags expiry on the cycle
// whose edge would bring the count to TIMEOUT_CYCLES.
module byte_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // Idle-cycle counter: cleared on accept or outside a load, else counts up.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Expiry is seen one cycle early so the FSM enters ERROR on the edge
    // that completes the TIMEOUT_CYCLES-th idle cycle.
    assign expired_o = enable_i && !clear_i && (count_q == LAST_IDLE);

endmodule

// File: rtl/program_loader.sv
// Serial program loader: parses a length-prefixed, XOR-checked byte image,
// writes it into instruction memory from address 0 and releases the CPU
// from reset only once the whole image has been written and verified.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH     = 11,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         load_start_in,
    input  logic [7:0]                   rx_data_in,
    input  logic                         rx_valid_in,
    output logic                         rx_ready_out,
    output logic                         imem_wr_out,
    output logic [OPERAND_WIDTH-1:0]     imem_address_out,
    output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
    output logic                         cpu_reset_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out,
    output logic [1:0]                   error_code_out
);

    localparam int unsigned IMEM_DEPTH = 1 << OPERAND_WIDTH;

    loader_state_e                state_q;
    logic                         rx_ready_q;
    logic                         imem_wr_q;
    logic [OPERAND_WIDTH-1:0]     addr_q;
    logic [INSTRUCTION_WIDTH-1:0] data_q;
    logic                         cpu_reset_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;
    logic [1:0]                   err_code_q;
    logic [7:0]                   len_hi_q;
    logic [7:0]                   word_hi_q;
    logic [15:0]                  remaining_q;
    logic [7:0]                   chk_q;

    logic accept;
    logic tmo_expired;

    // rx_ready_q is high exactly in the receive states, so it doubles as
    // the "load in progress" qualifier for acceptance and the idle timer.
    assign accept = rx_valid_in && rx_ready_q;

    byte_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock_i  (clock_in),
        .reset_i  (reset_in),
        .clear_i  (accept || !rx_ready_q),
        .enable_i (rx_ready_q),
        .expired_o(tmo_expired)
    );

    // Loader FSM with address/word counters, XOR accumulator and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            rx_ready_q  <= 1'b0;
            imem_wr_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            len_hi_q    <= '0;
            word_hi_q   <= '0;
            remaining_q <= '0;
            chk_q       <= '0;
        end else begin
            // Write strobe lasts one cycle; the address advances right after it.
            imem_wr_q <= 1'b0;
            if (imem_wr_q) begin
                addr_q <= addr_q + OPERAND_WIDTH'(1);
            end
            if (accept) begin
                chk_q <= chk_q ^ rx_data_in;
            end

            if (rx_ready_q && tmo_expired) begin
                state_q    <= ST_ERROR;
                err_code_q <= ERR_TIMEOUT;
                error_q    <= 1'b1;
                busy_q     <= 1'b0;
                rx_ready_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (load_start_in) begin
                            state_q     <= ST_LEN_HI;
                            addr_q      <= '0;
                            remaining_q <= '0;
                            chk_q       <= '0;
                            err_code_q  <= ERR_NONE;
                            rx_ready_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            error_q     <= 1'b0;
                            cpu_reset_q <= 1'b1;
                        end
                    end
                    ST_LEN_HI: begin
                        if (accept) begin
                            len_hi_q <= rx_data_in;
                            state_q  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (accept) begin
                            if (length_ok({len_hi_q, rx_data_in}, IMEM_DEPTH)) begin
                                remaining_q <= {len_hi_q, rx_data_in};
                                state_q     <= ST_DATA_HI;
                            end else begin
                                state_q    <= ST_ERROR;
                                err_code_q <= ERR_LEN;
                                error_q    <= 1'b1;
                                busy_q     <= 1'b0;
                                rx_ready_q <= 1'b0;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (accept) begin
                            word_hi_q <= rx_data_in;
                            state_q   <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        if (accept) begin
                            data_q      <= INSTRUCTION_WIDTH'({word_hi_q, rx_data_in});
                            imem_wr_q   <= 1'b1;
                            remaining_q <= remaining_q - 16'd1;
                            state_q     <= (remaining_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
                        end
                    end
                    ST_CHECK: begin
                        if (accept) begin
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                            if (rx_data_in == chk_q) begin
                                state_q     <= ST_DONE;
                                done_q      <= 1'b1;
                                cpu_reset_q <= 1'b0;
                            end else begin
                                state_q    <= ST_ERROR;
                                err_code_q <= ERR_CHK;
                                error_q    <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rx_ready_out     = rx_ready_q;
    assign imem_wr_out      = imem_wr_q;
    assign imem_address_out = addr_q;
    assign imem_data_out    = data_q;
    assign cpu_reset_out    = cpu_reset_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign error_out        = error_q;
    assign error_code_out   = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: byte-position model of the image format checked
// against every DUT output each cycle, plus literal expectations per scenario.
module tb_program_loader;

    localparam int OW  = 11;
    localparam int IW  = 16;
    localparam int TMO = 8;

    logic          clock_in      = 1'b0;
    logic          reset_in      = 1'b1;
    logic          load_start_in = 1'b0;
    logic [7:0]    rx_data_in    = 8'h00;
    logic          rx_valid_in   = 1'b0;
    logic          rx_ready_out;
    logic          imem_wr_out;
    logic [OW-1:0] imem_address_out;
    logic [IW-1:0] imem_data_out;
    logic          cpu_reset_out;
    logic          busy_out;
    logic          done_out;
    logic          error_out;
    logic [1:0]    error_code_out;

    program_loader #(
        .OPERAND_WIDTH    (OW),
        .INSTRUCTION_WIDTH(IW),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .load_start_in   (load_start_in),
        .rx_data_in      (rx_data_in),
        .rx_valid_in     (rx_valid_in),
        .rx_ready_out    (rx_ready_out),
        .imem_wr_out     (imem_wr_out),
        .imem_address_out(imem_address_out),
        .imem_data_out   (imem_data_out),
        .cpu_reset_out   (cpu_reset_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out),
        .error_code_out  (error_code_out)
    );

    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: position of each byte in the image decides its meaning.
    bit          m_loading = 0;
    bit          m_done    = 0;
    bit          m_error   = 0;
    logic [1:0]  m_code    = 2'b00;
    int          m_addr    = 0;
    bit          m_wr_pend = 0;
    logic [15:0] m_wr_data = 16'h0;
    int          m_idx     = 0;
    int          m_len     = 0;
    logic [7:0]  m_chk     = 8'h0;
    logic [7:0]  m_hi      = 8'h0;
    int          m_idle    = 0;

    function automatic void model_end(input bit ok, input logic [1:0] code);
        m_loading = 0;
        m_done    = ok;
        m_error   = !ok;
        m_code    = code;
    endfunction

    function automatic void model_step();
        logic [7:0] b;
        b = rx_data_in;
        if (reset_in) begin
            m_loading = 0; m_done = 0; m_error = 0; m_code = 2'b00;
            m_addr = 0; m_wr_pend = 0;
            return;
        end
        if (m_wr_pend) begin
            m_addr++;
            m_wr_pend = 0;
        end
        if (!m_loading) begin
            if (load_start_in) begin
                m_loading = 1; m_done = 0; m_error = 0; m_code = 2'b00;
                m_addr = 0; m_idx = 0; m_chk = 8'h0; m_idle = 0;
            end
        end else if (rx_valid_in) begin
            m_idle = 0;
            if (m_idx == 0) begin
                m_hi = b;
            end else if (m_idx == 1) begin
                m_len = int'({m_hi, b});
                if (m_len == 0 || m_len > (1 << OW)) model_end(0, 2'b01);
            end else if (m_idx < 2 + 2 * m_len) begin
                if (m_idx % 2 == 0) begin
                    m_hi = b;
                end else begin
                    m_wr_pend = 1;
                    m_wr_data = {m_hi, b};
                end
            end else begin
                if (b == m_chk) model_end(1, 2'b00);
                else model_end(0, 2'b10);
            end
            m_chk = m_chk ^ b;
            m_idx++;
        end else begin
            m_idle++;
            if (m_idle == TMO) model_end(0, 2'b11);
        end
    endfunction

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t wlog[$];
    wr_t ref_log[$];

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clock_in) begin
        check("rx_ready", 32'(rx_ready_out), 32'(m_loading));
        check("busy", 32'(busy_out), 32'(m_loading));
        check("done", 32'(done_out), 32'(m_done));
        check("error", 32'(error_out), 32'(m_error));
        check("error_code", 32'(error_code_out), 32'(m_code));
        check("cpu_reset", 32'(cpu_reset_out), 32'(!m_done));
        check("imem_wr", 32'(imem_wr_out), 32'(m_wr_pend));
        check("imem_addr", 32'(imem_address_out), 32'(m_addr));
        if (m_wr_pend) check("imem_data", 32'(imem_data_out), 32'(m_wr_data));
        if (imem_wr_out === 1'b1) wlog.push_back('{int'(imem_address_out), imem_data_out});
        model_step();
    end

    logic [7:0]  img[$];
    logic [15:0] words[$];

    function automatic void build_image(input logic [7:0] chk_flip);
        logic [7:0]  c;
        logic [15:0] n;
        n = 16'(words.size());
        img.delete();
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        foreach (words[i]) begin
            img.push_back(words[i][15:8]);
            img.push_back(words[i][7:0]);
        end
        c = 8'h00;
        foreach (img[i]) c = c ^ img[i];
        img.push_back(c ^ chk_flip);
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_start();
        load_start_in = 1'b1;
        tick();
        load_start_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            rx_valid_in = 1'b0;
            rx_data_in  = 8'($urandom);
            tick();
        end
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        tick();
        rx_valid_in = 1'b0;
        rx_data_in  = 8'($urandom);
    endtask

    // Sends img after a start pulse; optionally pulses load_start mid-load.
    task automatic run_load(input int maxgap, input bit mid_starts);
        wlog.delete();
        pulse_start();
        foreach (img[i]) begin
            if (mid_starts && $urandom_range(0, 3) == 0) load_start_in = 1'b1;
            send_byte(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            load_start_in = 1'b0;
        end
        repeat (3) tick();
    endtask

    // Counts edges from the last accept until error_out rises (bounded).
    task automatic wait_error(output int k);
        k = 0;
        while (error_out !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
    endtask

    int k;

    initial begin
        repeat (3) tick();
        reset_in = 1'b0;
        check("reset_data", 32'(imem_data_out), 32'h0);
        check("reset_cpu_reset", 32'(cpu_reset_out), 32'h1);

        // Good two-word image.
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(0, 0);
        check("t1_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("t1_w0_addr", 32'(wlog[0].addr), 32'd0);
            check("t1_w0_data", 32'(wlog[0].data), 32'h1234);
            check("t1_w1_addr", 32'(wlog[1].addr), 32'd1);
            check("t1_w1_data", 32'(wlog[1].data), 32'hABCD);
        end
        check("t1_done", 32'(done_out), 32'h1);
        check("t1_cpu_reset", 32'(cpu_reset_out), 32'h0);
        ref_log = wlog;

        // Bad checksum: words stay written, error code 10.
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_load(0, 0);
        check("t2_nwrites", 32'(wlog.size()), 32'd2);
        check("t2_error", 32'(error_out), 32'h1);
        check("t2_code", 32'(error_code_out), 32'h2);
        check("t2_cpu_reset", 32'(cpu_reset_out), 32'h1);

        // Zero length and oversize length.
        img = '{8'h00, 8'h00};
        run_load(0, 0);
        check("t3_code", 32'(error_code_out), 32'h1);
        check("t3_nwrites", 32'(wlog.size()), 32'd0);
        img = '{8'h08, 8'h01};
        run_load(0, 0);
        check("t4_code", 32'(error_code_out), 32'h1);

        // Timeout after a DATA_HI byte.
        wlog.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        wait_error(k);
        check("t5_timeout_latency", 32'(k), 32'd8);
        check("t5_code", 32'(error_code_out), 32'h3);

        // Maximum length 2048 is accepted, so the stall ends in a timeout.
        pulse_start();
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        wait_error(k);
        check("t5b_timeout_latency", 32'(k), 32'd8);
        check("t5b_code", 32'(error_code_out), 32'h3);

        // Same good image with random valid gaps and ignored mid-load starts.
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(4, 1);
        check("t6_nwrites", 32'(wlog.size()), 32'(ref_log.size()));
        foreach (wlog[i]) begin
            if (i < ref_log.size()) begin
                check("t6_addr", 32'(wlog[i].addr), 32'(ref_log[i].addr));
                check("t6_data", 32'(wlog[i].data), 32'(ref_log[i].data));
            end
        end
        check("t6_done", 32'(done_out), 32'h1);

        // Random images, some with corrupted checksum.
        for (int r = 0; r < 8; r++) begin
            bit corrupt;
            corrupt = ($urandom_range(0, 3) == 0);
            words.delete();
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) words.push_back(16'($urandom));
            build_image(corrupt ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            run_load(4, !corrupt);
            check("rand_nwrites", 32'(wlog.size()), 32'(words.size()));
            check("rand_done", 32'(done_out), 32'(!corrupt));
            check("rand_error", 32'(error_out), 32'(corrupt));
        end

        // Reset while in DATA_LO, then a fresh load from address 0.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("t7_ready", 32'(rx_ready_out), 32'h0);
        check("t7_busy", 32'(busy_out), 32'h0);
        check("t7_addr", 32'(imem_address_out), 32'h0);
        check("t7_cpu_reset", 32'(cpu_reset_out), 32'h1);
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(0, 0);
        check("t7_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 0) check("t7_first_addr", 32'(wlog[0].addr), 32'd0);
        check("t7_done", 32'(done_out), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
